// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
//   Single-clock first-in/first-out buffer. A producer and a consumer hand off
//   data words through DEPTH storage entries, each side using its own request
//   line. Words leave in the order they were written.
//
//   Ports
//     clk         single clock; all state changes on the rising edge
//     rst_n       asynchronous active-low reset
//     i_wr_en     write request
//     i_wr_data   write data, sampled with i_wr_en
//     i_rd_en     read request
//     o_rd_data   registered read data, valid one cycle after an accepted read
//     o_wr_full   all DEPTH entries are occupied
//     o_rd_empty  no entries are occupied
//
//   Parameters
//     DEPTH  number of entries (power of two, >= 2)
//     WIDTH  data word width in bits
// -----------------------------------------------------------------------------
module async_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_wr_full,
  output logic             o_rd_empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra wrap bit distinguishes "full" from "empty" when the addresses
  // coincide; the pointers count modulo 2*DEPTH.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Flags come straight from the registered pointers, so they move in the
  // same cycle the pointers do.
  assign o_rd_empty = (wr_ptr == rd_ptr);
  assign o_wr_full  = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);

  // A write while full and a read while empty are simply ignored, which keeps
  // occupancy within 0..DEPTH. When empty, a simultaneous write is not
  // bypassed to the read port.
  assign wr_accept = i_wr_en && !o_wr_full;
  assign rd_accept = i_rd_en && !o_rd_empty;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries hold live data, so clearing the array would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read data is registered and holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      o_rd_data <= '0;
    end else if (rd_accept) begin
      rd_ptr    <= rd_ptr + 1'b1;
      o_rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
//   Self-checking bench for async_fifo (DEPTH=4, WIDTH=8). A queue-based
//   reference holds the words the FIFO should contain; each stimulus cycle
//   decides acceptance from the reference occupancy, pops the expected read
//   word, and compares read data and flags one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_async_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             wr_full;
  logic             rd_empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_data;

  async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_wr_full  (wr_full),
    .o_rd_empty (rd_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, with the reference updated from its own
  // pre-edge occupancy and the DUT sampled 1 time unit after the edge.
  task automatic cycle(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    logic wr_ok;
    logic rd_ok;
    @(negedge clk);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    wr_ok = wr && (sb.size() < DEPTH);
    rd_ok = rd && (sb.size() > 0);
    if (rd_ok) exp_data = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    check("rd_data", {24'd0, rd_data}, {24'd0, exp_data});
    check("empty", {31'd0, rd_empty}, {31'd0, sb.size() == 0});
    check("full", {31'd0, wr_full}, {31'd0, sb.size() == DEPTH});
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    exp_data = '0;

    // 1. Reset state before any clock edge, then after release.
    #2;
    check("rst_empty", {31'd0, rd_empty}, 32'd1);
    check("rst_full", {31'd0, wr_full}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_empty", {31'd0, rd_empty}, 32'd1);
    check("rel_full", {31'd0, wr_full}, 32'd0);

    // 2. Single transfers: fixed then random words.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_a5", {24'd0, rd_data}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      cycle(1'b1, r, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      check("single_rand", {24'd0, rd_data}, {24'd0, r});
    end

    // 3. Fill, overflow attempt, drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full", {31'd0, wr_full}, 32'd1);
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_order", {24'd0, rd_data}, i);
    end
    check("drain_empty", {31'd0, rd_empty}, 32'd1);

    // 4. Underflow: read while empty holds data, then normal transfer.
    cycle(1'b0, 8'h00, 1'b1);
    check("underflow_hold", {24'd0, rd_data}, 32'h04);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("after_underflow", {24'd0, rd_data}, 32'h3C);

    // 5a. Streaming across pointer wrap with occupancy held at one.
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h81 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("stream_last", {24'd0, rd_data}, 32'h8C);

    // 5b. Full with simultaneous read and write: write dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    check("full_rw_data", {24'd0, rd_data}, 32'h50);
    check("full_rw_clear", {31'd0, wr_full}, 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);

    // 6. Reset in the middle of operation discards contents.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", {31'd0, rd_empty}, 32'd1);
    check("mid_rst_full", {31'd0, wr_full}, 32'd0);
    check("mid_rst_data", {24'd0, rd_data}, 32'd0);
    sb.delete();
    exp_data = '0;
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst", {24'd0, rd_data}, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
